// File: rtl/reg_file_scrub.sv
// Parametrised register file: one write port, two combinational read ports,
// optional write bypass, optional hardwired-zero r0 and a one-entry-per-cycle scrub engine.
module reg_file_scrub #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              WERR,
  output logic              state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, SCRUB = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              idle_write;
  logic              write_ok;
  logic              write_drop;

  // A write lands only in IDLE without a competing scrub request; CLEAR wins.
  assign idle_write = WRITE && (state == IDLE) && !CLEAR;
  assign write_ok   = idle_write && !(ZERO_R0 && (INADDRESS == '0));
  assign write_drop = WRITE && ((state == SCRUB) || CLEAR);

  assign BUSY      = (state == SCRUB);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (CLEAR) begin
          state_next = SCRUB;
          ptr_next   = '0;
        end
      end
      SCRUB: begin
        ptr_next = ptr + 1'b1;
        if (ptr == LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      ptr   <= '0;
      WERR  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      WERR  <= write_drop;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == SCRUB) begin
      regs[ptr] <= '0;
    end else if (write_ok) begin
      regs[INADDRESS] <= IN;
    end
  end

  // Zero-r0 override takes precedence over forwarding of an in-flight write.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = regs[addr];
    if (ZERO_R0 && (addr == '0)) data = '0;
    else if (BYPASS && idle_write && (INADDRESS == addr)) data = IN;
    return data;
  endfunction

  assign OUT1 = read_port(OUT1ADDRESS);
  assign OUT2 = read_port(OUT2ADDRESS);

endmodule

// File: tb/tb_reg_file_scrub.sv
// Directed bench for reg_file_scrub: three instances (default, no bypass, zero-r0)
// share one stimulus stream and are checked against hand-computed values.
module tb_reg_file_scrub;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       CLEAR;

  logic [7:0] out1_a, out2_a, out1_n, out2_n, out1_z, out2_z;
  logic       busy_a, werr_a, st_a, busy_n, werr_n, st_n, busy_z, werr_z, st_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  reg_file_scrub #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_a), .OUT2(out2_a),
    .CLEAR(CLEAR), .BUSY(busy_a), .WERR(werr_a), .state_dbg(st_a));

  reg_file_scrub #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nobyp (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_n), .OUT2(out2_n),
    .CLEAR(CLEAR), .BUSY(busy_n), .WERR(werr_n), .state_dbg(st_n));

  reg_file_scrub #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_z0 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_z), .OUT2(out2_z),
    .CLEAR(CLEAR), .BUSY(busy_z), .WERR(werr_z), .state_dbg(st_z));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs held across it.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RESET = 1'b0; IN = '0; INADDRESS = '0; WRITE = 1'b0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0; CLEAR = 1'b0;
    #1;
    chk("rst_out1", out1_a, 8'h00);
    chk("rst_out2", out2_a, 8'h00);
    chk("rst_busy", {7'd0, busy_a}, 8'h00);
    chk("rst_werr", {7'd0, werr_a}, 8'h00);
    tick(); tick();
    RESET = 1'b1;
    tick();

    // Plain writes then reads next cycle
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'hA5; tick();
    INADDRESS = 3'd7; IN = 8'h5A; tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7; #1;
    chk("rd_r3", out1_a, 8'hA5);
    chk("rd_r7", out2_a, 8'h5A);
    chk("rd_r3_nobyp", out1_n, 8'hA5);
    chk("werr_idle", {7'd0, werr_a}, 8'h00);
    RESET = 1'b0; #1;
    chk("async_rst_out1", out1_a, 8'h00);
    chk("async_rst_out2", out2_a, 8'h00);
    #1; RESET = 1'b1;
    tick();

    // Bypass vs. no bypass
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h3C; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd2; #1;
    chk("byp_out1", out1_a, 8'h3C);
    chk("byp_out2_same", out2_a, 8'h3C);
    chk("nobyp_old", out1_n, 8'h00);
    tick();
    WRITE = 1'b0; #1;
    chk("nobyp_after", out1_n, 8'h3C);

    // Fill r0..r7 with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'(17 * (i + 1)); tick();
    end
    WRITE = 1'b0; OUT1ADDRESS = 3'd0; #1;
    chk("fill_r0", out1_a, 8'h11);
    chk("z0_r0", out1_z, 8'h00);
    chk("z0_no_werr", {7'd0, werr_z}, 8'h00);

    // Scrub: edge k
    CLEAR = 1'b1; tick();
    CLEAR = 1'b0; #1;
    chk("scrub_busy_k", {7'd0, busy_a}, 8'h01);
    chk("scrub_state", {7'd0, st_a}, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(i + 4); #1;
      chk("mid_lo", out1_a, 8'h00);
      chk("mid_hi", out2_a, 8'(17 * (i + 5)));
    end
    // Write during scrub, with a CLEAR that must be ignored
    WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'hFF; CLEAR = 1'b1; OUT2ADDRESS = 3'd5; #1;
    chk("no_byp_in_scrub", out2_a, 8'h66);
    tick();
    WRITE = 1'b0; CLEAR = 1'b0; #1;
    chk("werr_scrub", {7'd0, werr_a}, 8'h01);
    tick(); #1;
    chk("werr_pulse_end", {7'd0, werr_a}, 8'h00);
    tick(); #1;
    chk("busy_k7", {7'd0, busy_a}, 8'h01);
    tick(); #1;
    chk("busy_k8", {7'd0, busy_a}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); #1;
      chk("post_scrub", out1_a, 8'h00);
    end

    // WRITE with CLEAR in IDLE, then back-to-back dropped writes
    WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h99; CLEAR = 1'b1; OUT1ADDRESS = 3'd1; #1;
    chk("clr_blocks_byp", out1_a, 8'h00);
    tick();
    CLEAR = 1'b0; #1;
    chk("werr_clr", {7'd0, werr_a}, 8'h01);
    tick(); #1;
    chk("werr_b2b", {7'd0, werr_a}, 8'h01);
    WRITE = 1'b0;
    tick(); #1;
    chk("werr_b2b_end", {7'd0, werr_a}, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("busy2_k7", {7'd0, busy_a}, 8'h01);
    tick(); #1;
    chk("busy2_k8", {7'd0, busy_a}, 8'h00);

    // Zero-r0 with bypass conditions active
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h77; OUT1ADDRESS = 3'd0; #1;
    chk("z0_byp", out1_z, 8'h00);
    chk("r0_byp_default", out1_a, 8'h77);
    tick();
    WRITE = 1'b0; #1;
    chk("z0_after", out1_z, 8'h00);
    chk("z0_werr", {7'd0, werr_z}, 8'h00);
    chk("r0_default", out1_a, 8'h77);

    // Reset in the middle of a scrub
    WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'hEE; tick();
    WRITE = 1'b0; CLEAR = 1'b1; tick();
    CLEAR = 1'b0; tick(); tick();
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd6; #1;
    chk("mid_r0_scrubbed", out1_a, 8'h00);
    chk("mid_r6_kept", out2_a, 8'hEE);
    RESET = 1'b0; #1;
    chk("rst_mid_busy", {7'd0, busy_a}, 8'h00);
    chk("rst_mid_r6", out2_a, 8'h00);
    #1; RESET = 1'b1;
    tick();
    WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h42; tick();
    WRITE = 1'b0; #1;
    chk("post_rst_r6", out2_a, 8'h42);
    chk("post_rst_werr", {7'd0, werr_a}, 8'h00);
    chk("post_rst_busy", {7'd0, busy_a}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_scrub.md
Name: reg_file_scrub

Overview:
Parametrised successor to the 8x8 CPU register file. It has one write port and two combinational read ports, with configurable width and depth. It adds optional write-to-read bypass, optional hardwired-zero register 0, and a sequential scrub engine that clears the array one entry per cycle on request. It sits between the instruction decoder/ALU and the write-back path of the single-cycle CPU.

Parameters:
WIDTH, 8, data bits per register
ADDR_W, 3, address bits; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read output
ZERO_R0, 0, 1 = register 0 always reads 0 and writes to it are discarded

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
IN  input  WIDTH  write data
INADDRESS  input  ADDR_W  write address
WRITE  input  1  write enable, sampled at rising CLK
OUT1ADDRESS  input  ADDR_W  read port 1 address
OUT2ADDRESS  input  ADDR_W  read port 2 address
OUT1  output  WIDTH  read port 1 data (combinational)
OUT2  output  WIDTH  read port 2 data (combinational)
CLEAR  input  1  scrub request, sampled at rising CLK
BUSY  output  1  registered; 1 while scrub in progress
WERR  output  1  registered one-cycle pulse: a write was dropped

Behaviour:
- Reset (RESET=0, asynchronous, no clock needed):
  - all registers = 0; FSM = IDLE; scrub pointer = 0; BUSY = 0; WERR = 0.
  - OUT1/OUT2 therefore read 0 immediately.
  - Deassertion takes effect at the next rising CLK.
- Read path, purely combinational:
  - OUTx = REG[OUTxADDRESS].
  - Override 1: if ZERO_R0=1 and OUTxADDRESS=0, OUTx = 0.
  - Override 2: else if BYPASS=1, WRITE=1, BUSY=0, CLEAR=0 and INADDRESS=OUTxADDRESS, OUTx = IN.
- Write, IDLE and CLEAR=0:
  - WRITE=1 -> REG[INADDRESS] <= IN at the rising edge, visible without bypass in the following cycle.
  - If ZERO_R0=1 and INADDRESS=0, the write is discarded silently (no WERR).
- FSM states are IDLE and SCRUB.
  - IDLE + CLEAR=1 at edge k -> SCRUB, pointer = 0, BUSY = 1 after edge k.
  - SCRUB, edges k+1 .. k+DEPTH: REG[pointer] <= 0, pointer increments.
  - At edge k+DEPTH (pointer = DEPTH-1): state -> IDLE, BUSY -> 0, pointer -> 0. Total BUSY high time = DEPTH cycles.
  - CLEAR while in SCRUB is ignored; the scrub does not restart or extend.
- Dropped writes:
  - WRITE=1 at an edge where BUSY=1, or where IDLE with CLEAR=1, -> no array update; WERR=1 for exactly the next cycle.
  - CLEAR has priority over WRITE.
  - Back-to-back dropped writes keep WERR high continuously.
- Reads during SCRUB return current array contents: already-scrubbed entries read 0, the rest keep old data. Bypass is inactive during SCRUB.
- Pointer wrap: the pointer is ADDR_W bits; the last clear is at DEPTH-1 and there is no extra cycle.
- Reset mid-scrub: immediate return to IDLE with all registers 0 and BUSY=0.
- Both read ports may address the same register, including the write target; both see identical data.

Test Plan (WIDTH=8, ADDR_W=3 unless stated):
1. Reset -> write 0xA5 to r3, 0x5A to r7 -> next cycle OUT1ADDRESS=3, OUT2ADDRESS=7: OUT1=0xA5, OUT2=0x5A. Pulse RESET=0 between edges: both outputs read 0x00 before the next edge.
2. BYPASS=1: WRITE=1, INADDRESS=2, IN=0x3C, OUT1ADDRESS=2 in the same cycle -> OUT1=0x3C before the edge. Repeat with BYPASS=0 -> OUT1 shows the old value 0x00 until after the edge.
3. Fill r0..r7 with 0x11..0x88, assert CLEAR 1 cycle -> BUSY high for exactly 8 cycles. After 4 scrub edges: r0..r3 read 0x00, r4..r7 read 0x55..0x88. After BUSY falls, all read 0x00.
4. During SCRUB assert WRITE=1, INADDRESS=5, IN=0xFF -> WERR=1 the next cycle and r5 stays 0 after the scrub. WRITE together with CLEAR in IDLE -> write dropped, WERR pulses once.
5. ZERO_R0=1: write 0x77 to r0 -> OUT1 (addr 0) = 0x00 and WERR stays 0. Repeat with bypass conditions active -> still 0x00.
6. Start a scrub, drive RESET=0 at cycle 3 of SCRUB -> BUSY=0 immediately and all reads 0. After release, write 0x42 to r6 succeeds with no WERR.
